// File: rtl/arb_pkg.sv
// Shared types and helpers for prio_arbiter_rr_hold.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Binary index of a one-hot vector. Only the low 'width' bits are
  // considered, and up to 32 requesters are supported. A zero vector yields
  // index 0.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh, input int width);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (i < width && oh[i]) idx = idx | 5'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational MSB-first pick with a rotatable start point.
// In round-robin mode the request vector is rotated right by ptr, so
// req[ptr-1] lands on the MSB and req[ptr] on bit 0 (lowest priority).
// The pick is then rotated back. Fixed mode uses a rotation of zero.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [SIZE-1:0]  win,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] rot;
  logic [SIZE-1:0]  req_rot;
  logic [SIZE-1:0]  pick_rot;

  assign rot = (mode == ARB_RR) ? ptr : '0;

  // Rotate right by rot, modulo SIZE, so that non-power-of-two sizes work.
  always_comb begin
    logic [IDX_W-1:0] j;
    req_rot = '0;
    for (int i = 0; i < SIZE; i++) begin
      j = IDX_W'((i + int'(rot)) % SIZE);
      req_rot[i] = req[j];
    end
  end

  // MSB-first pick on the rotated vector.
  always_comb begin
    logic found;
    pick_rot = '0;
    found    = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!found && req_rot[i]) begin
        pick_rot[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Rotate the pick back into requester order.
  always_comb begin
    logic [IDX_W-1:0] j;
    win = '0;
    for (int i = 0; i < SIZE; i++) begin
      j = IDX_W'((i + int'(rot)) % SIZE);
      win[j] = pick_rot[i];
    end
  end

  assign win_idx = IDX_W'(onehot_to_idx(32'(win), SIZE));

endmodule

// File: rtl/prio_arbiter_rr_hold.sv
// Registered N-way arbiter with a locked multi-beat grant.
// The mode input selects fixed MSB-first priority or round-robin with the
// same search direction. A grant is released only by ack & last. Once a
// grant is released, arbitration runs again in the same cycle, so there is
// no idle bubble between holders.
// Optional feature: define ARB_HOLD_TIMEOUT_EN to build a stall counter.
// The counter force-releases a grant after MAX_HOLD cycles without an ack,
// and timeout pulses in the cycle that the forced release takes effect.
module prio_arbiter_rr_hold
  import arb_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int IDX_W    = $clog2(SIZE),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  req,
  input  logic             mode,
  input  logic             ack,
  input  logic             last,
  output logic [SIZE-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [SIZE-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             force_rel;
  logic             arb_now;

  rr_prio_pick #(.SIZE(SIZE), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .mode    (arb_mode_e'(mode)),
    .win     (pick_gnt),
    .win_idx (pick_idx)
  );

  // Arbitrate whenever idle, and on every release of the current holder.
  assign arb_now = (state == ARB_IDLE) || (ack && last) || force_rel;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] hold_cnt;

  assign force_rel = (state == ARB_GRANT) && !ack && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Stall counter: counts grant cycles, restarts on any ack or new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 hold_cnt <= '0;
    else if (ack || arb_now) hold_cnt <= '0;
    else                     hold_cnt <= hold_cnt + 1'b1;
  end

  // Timeout flag aligned with the grant change caused by a forced release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= force_rel;
  end
`else
  logic unused_hold;
  assign unused_hold = (MAX_HOLD > 0);
  assign force_rel   = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Grant FSM with registered outputs. ptr records every issued grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
    end else if (arb_now) begin
      gnt       <= pick_gnt;
      gnt_valid <= |pick_gnt;
      gnt_idx   <= pick_idx;
      if (|pick_gnt) begin
        state <= ARB_GRANT;
        ptr   <= pick_idx;
      end else begin
        state <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_prio_arbiter_rr_hold.sv
// Directed bench for prio_arbiter_rr_hold (SIZE=4, MAX_HOLD=8).
// The timeout scenario follows ARB_HOLD_TIMEOUT_EN.
module tb_prio_arbiter_rr_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mode, ack, last;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  prio_arbiter_rr_hold #(.SIZE(4), .IDX_W(2), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .ack       (ack),
    .last      (last),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Check grant, valid and index together.
  task automatic chk_g(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(|eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; mode = 1'b0; ack = 1'b0; last = 1'b0;

    // Reset holds everything at zero despite pending requests
    tick; tick;
    chk_g("rst", 4'b0000, 2'd0);
    chk("rst.to", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick;
    chk_g("rst_first", 4'b1000, 2'd3);
    req = 4'b0000; ack = 1'b1; last = 1'b1;
    tick;
    chk_g("rst_drain", 4'b0000, 2'd0);

    // Fixed priority with a back-to-back handover
    mode = 1'b0; req = 4'b0101; ack = 1'b0; last = 1'b0;
    tick;
    chk_g("fix_a", 4'b0100, 2'd2);
    req = 4'b0001; ack = 1'b1; last = 1'b1;
    tick;
    chk_g("fix_b", 4'b0001, 2'd0);
    req = 4'b0000;
    tick;
    chk_g("fix_idle", 4'b0000, 2'd0);

    // Round-robin rotation, then fixed mode stays on the MSB requester
    mode = 1'b1; req = 4'b1111;
    tick; chk_g("rr0", 4'b1000, 2'd3);
    tick; chk_g("rr1", 4'b0100, 2'd2);
    tick; chk_g("rr2", 4'b0010, 2'd1);
    tick; chk_g("rr3", 4'b0001, 2'd0);
    tick; chk_g("rr4", 4'b1000, 2'd3);
    mode = 1'b0;
    tick; chk_g("fx0", 4'b1000, 2'd3);
    tick; chk_g("fx1", 4'b1000, 2'd3);
    req = 4'b0000;
    tick; chk_g("fx_idle", 4'b0000, 2'd0);

    // Lock: the grant survives req changes and non-last acks
    ack = 1'b0; last = 1'b0; req = 4'b0010;
    tick; chk_g("lock_g", 4'b0010, 2'd1);
    req = 4'b0000;
    tick; chk_g("lock_drop", 4'b0010, 2'd1);
    req = 4'b1000;
    tick; chk_g("lock_hi", 4'b0010, 2'd1);
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; chk_g("lock_ack", 4'b0010, 2'd1);
    end
    last = 1'b1;
    tick; chk_g("lock_rel", 4'b1000, 2'd3);
    req = 4'b0000;
    tick; chk_g("lock_idle", 4'b0000, 2'd0);

    // Hold limit
    ack = 1'b0; last = 1'b0; req = 4'b0100;
    tick; chk_g("to_g", 4'b0100, 2'd2);
    req = 4'b0001;
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      tick;
      chk_g("to_hold", 4'b0100, 2'd2);
      chk("to_hold.to", 32'(timeout), 32'd0);
    end
    tick;
    chk_g("to_rel", 4'b0001, 2'd0);
    chk("to_rel.to", 32'(timeout), 32'd1);
    tick;
    chk("to_pulse_end", 32'(timeout), 32'd0);
    req = 4'b0000; ack = 1'b1; last = 1'b1;
    tick; chk_g("to_idle", 4'b0000, 2'd0);
    // An ack in cycle 5 restarts the count: release after cycle 13
    ack = 1'b0; last = 1'b0; req = 4'b0100;
    tick; chk_g("tor_g", 4'b0100, 2'd2);
    req = 4'b0001;
    for (int k = 1; k <= 13; k++) begin
      ack = (k == 5);
      tick;
      if (k < 13) begin
        chk_g("tor_hold", 4'b0100, 2'd2);
        chk("tor_hold.to", 32'(timeout), 32'd0);
      end else begin
        chk_g("tor_rel", 4'b0001, 2'd0);
        chk("tor_rel.to", 32'(timeout), 32'd1);
      end
    end
`else
    for (int k = 0; k < 110; k++) begin
      tick;
      chk_g("hold", 4'b0100, 2'd2);
      chk("hold.to", 32'(timeout), 32'd0);
    end
`endif
    req = 4'b0000; ack = 1'b1; last = 1'b1;
    tick; chk_g("hold_idle", 4'b0000, 2'd0);

    // Asynchronous reset mid-transfer, then ptr is back at zero
    mode = 1'b1; ack = 1'b0; last = 1'b0; req = 4'b0010;
    tick; chk_g("ar_g", 4'b0010, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk_g("ar_async", 4'b0000, 2'd0);
    chk("ar_async.to", 32'(timeout), 32'd0);
    #1 rst = 1'b0;
    req = 4'b0011;
    tick; chk_g("ar_ptr0", 4'b0010, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
